// File: rtl/recv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : recv_pkg
//  Purpose  : Shared types and constants for the receive controller slice.
//             Width defaults, router IDs (common with the send side), the
//             data-path FSM state encoding and the packet-type constant.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package recv_pkg;

  localparam int SEQ_NUM_WIDTH_DEF = 1;
  localparam int DFX_WIDTH_DEF     = 2;
  localparam int CNT_WIDTH_DEF     = 8;

  // Router IDs, identical to the ones used by the send controller.
  localparam logic [DFX_WIDTH_DEF-1:0] ROUTER0 = 2'd0;
  localparam logic [DFX_WIDTH_DEF-1:0] ROUTER1 = 2'd1;
  localparam logic [DFX_WIDTH_DEF-1:0] ROUTER2 = 2'd2;
  localparam logic [DFX_WIDTH_DEF-1:0] ROUTER3 = 2'd3;

  // Value of pkt_is_ack that marks an ACK header.
  localparam logic PKT_TYPE_ACK = 1'b1;

  // Data-path FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DELIVER  = 2'd2,
    ST_SEND_ACK = 2'd3
  } data_state_e;

endpackage
`default_nettype wire

// File: rtl/recv_if.sv
`default_nettype none
// ============================================================================
//  Module   : recv_if
//  Purpose  : Bundles every non-clock/reset signal of the receive controller.
//  Modports : master - environment side (depacketizer, send controller,
//                      delivery block, ACK encapsulator)
//             slave  - recv_controller side
//  Signals  : my_dfx, pkt_* header handshake, valid/wait ACK forward,
//             deliver request/done, ACK encap request/done, drop_cnt
//  Revision : 1.0 - initial release
// ============================================================================
interface recv_if
  import recv_pkg::*;
#(
  parameter int SEQ_NUM_WIDTH = SEQ_NUM_WIDTH_DEF,
  parameter int DFX_WIDTH     = DFX_WIDTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
);

  logic [DFX_WIDTH-1:0]     my_dfx;
  // Header handshake from the depacketizer
  logic                     pkt_valid;
  logic                     pkt_ready;
  logic                     pkt_is_ack;
  logic [DFX_WIDTH-1:0]     pkt_src_dfx;
  logic [DFX_WIDTH-1:0]     pkt_dst_dfx;
  logic [SEQ_NUM_WIDTH-1:0] pkt_sn;
  logic                     pkt_err;
  // ACK forward to the send controller
  logic                     wait_ack_pkt_recv;
  logic                     valid_ack_pkt_recv;
  logic [SEQ_NUM_WIDTH-1:0] rn_ack_pkt_recv;
  logic [DFX_WIDTH-1:0]     src_dfx_ack_pkt_recv;
  // Payload delivery
  logic                     start_deliver;
  logic [DFX_WIDTH-1:0]     deliver_src_dfx;
  logic                     deliver_done;
  // ACK encapsulation
  logic                     start_ack_encap;
  logic [DFX_WIDTH-1:0]     ack_src_dfx;
  logic [DFX_WIDTH-1:0]     ack_dst_dfx;
  logic [SEQ_NUM_WIDTH-1:0] ack_rn;
  logic                     done_ack_encap;
  // Statistics
  logic [CNT_WIDTH-1:0]     drop_cnt;

  modport master (
    output my_dfx, pkt_valid, pkt_is_ack, pkt_src_dfx, pkt_dst_dfx, pkt_sn,
           pkt_err, wait_ack_pkt_recv, deliver_done, done_ack_encap,
    input  pkt_ready, valid_ack_pkt_recv, rn_ack_pkt_recv, src_dfx_ack_pkt_recv,
           start_deliver, deliver_src_dfx, start_ack_encap, ack_src_dfx,
           ack_dst_dfx, ack_rn, drop_cnt
  );

  modport slave (
    input  my_dfx, pkt_valid, pkt_is_ack, pkt_src_dfx, pkt_dst_dfx, pkt_sn,
           pkt_err, wait_ack_pkt_recv, deliver_done, done_ack_encap,
    output pkt_ready, valid_ack_pkt_recv, rn_ack_pkt_recv, src_dfx_ack_pkt_recv,
           start_deliver, deliver_src_dfx, start_ack_encap, ack_src_dfx,
           ack_dst_dfx, ack_rn, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/recv_controller_ack_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ack_forward_buf
//  Purpose  : One-entry buffer for received ACK headers and the
//             valid/wait strobe toward the send controller.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             load, load_src,
//             load_rn            - write a new ACK into the buffer
//             wait_ack           - send controller is waiting for an ACK
//             valid, src, rn     - registered one-cycle forward strobe + data
//             overwrite          - a buffered ACK was replaced before it
//                                  could be forwarded (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module ack_forward_buf
  import recv_pkg::*;
#(
  parameter int SEQ_NUM_WIDTH = SEQ_NUM_WIDTH_DEF,
  parameter int DFX_WIDTH     = DFX_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [DFX_WIDTH-1:0]     load_src,
  input  logic [SEQ_NUM_WIDTH-1:0] load_rn,
  input  logic                     wait_ack,
  output logic                     valid,
  output logic [DFX_WIDTH-1:0]     src,
  output logic [SEQ_NUM_WIDTH-1:0] rn,
  output logic                     overwrite
);

  logic                     full_q, full_d;
  logic [DFX_WIDTH-1:0]     buf_src_q, buf_src_d;
  logic [SEQ_NUM_WIDTH-1:0] buf_rn_q, buf_rn_d;
  logic                     valid_q, valid_d;
  logic [DFX_WIDTH-1:0]     src_q, src_d;
  logic [SEQ_NUM_WIDTH-1:0] rn_q, rn_d;
  logic                     fwd;

  // Blocking on valid_q keeps the strobe to a single cycle even when the
  // send controller holds wait_ack high.
  assign fwd       = full_q && wait_ack && !valid_q;
  // A load coinciding with a forward is not an overwrite: the old entry
  // leaves through the forward path in the same cycle.
  assign overwrite = load && full_q && !fwd;

  always_comb begin
    full_d    = full_q;
    buf_src_d = buf_src_q;
    buf_rn_d  = buf_rn_q;
    if (load) begin
      full_d    = 1'b1;
      buf_src_d = load_src;
      buf_rn_d  = load_rn;
    end else if (fwd) begin
      full_d = 1'b0;
    end
    valid_d = fwd;
    src_d   = fwd ? buf_src_q : '0;
    rn_d    = fwd ? buf_rn_q  : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 1'b0;
      buf_src_q <= '0;
      buf_rn_q  <= '0;
      valid_q   <= 1'b0;
      src_q     <= '0;
      rn_q      <= '0;
    end else begin
      full_q    <= full_d;
      buf_src_q <= buf_src_d;
      buf_rn_q  <= buf_rn_d;
      valid_q   <= valid_d;
      src_q     <= src_d;
      rn_q      <= rn_d;
    end
  end

  assign valid = valid_q;
  assign src   = src_q;
  assign rn    = rn_q;

endmodule
`default_nettype wire

// File: rtl/recv_controller.sv
`default_nettype none
// ============================================================================
//  Module   : recv_controller
//  Purpose  : Receive-side stop-and-wait controller. Filters incoming
//             headers, checks data sequence numbers against a per-source
//             expected RN, drives payload delivery and ACK generation, and
//             forwards received ACKs to the send controller.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - recv_if.slave: header handshake, ACK forward,
//                    delivery, ACK encap and drop counter signals
//  Revision : 1.0 - initial release
// ============================================================================
module recv_controller
  import recv_pkg::*;
#(
  parameter int SEQ_NUM_WIDTH = SEQ_NUM_WIDTH_DEF,
  parameter int DFX_WIDTH     = DFX_WIDTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic  clk,
  input  logic  rst,
  recv_if.slave bus
);

  localparam int                   NUM_SRC = 2 ** DFX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  data_state_e              state_q, state_d;
  logic [DFX_WIDTH-1:0]     src_q, src_d;
  logic [SEQ_NUM_WIDTH-1:0] sn_q, sn_d;
  logic [SEQ_NUM_WIDTH-1:0] exp_rn_q [NUM_SRC];
  logic [SEQ_NUM_WIDTH-1:0] exp_rn_d [NUM_SRC];

  logic                     pkt_ready_q, pkt_ready_d;
  logic                     start_deliver_q, start_deliver_d;
  logic [DFX_WIDTH-1:0]     deliver_src_q, deliver_src_d;
  logic                     start_ack_encap_q, start_ack_encap_d;
  logic [DFX_WIDTH-1:0]     ack_src_q, ack_src_d;
  logic [DFX_WIDTH-1:0]     ack_dst_q, ack_dst_d;
  logic [SEQ_NUM_WIDTH-1:0] ack_rn_q, ack_rn_d;
  logic [CNT_WIDTH-1:0]     drop_cnt_q, drop_cnt_d;

  logic                     accept;
  logic                     hdr_bad;
  logic                     ack_load;
  logic                     data_accept;
  logic                     dup;
  logic                     ack_overwrite;
  logic                     fwd_valid;
  logic [DFX_WIDTH-1:0]     fwd_src;
  logic [SEQ_NUM_WIDTH-1:0] fwd_rn;

  // pkt_ready_q is high exactly when the FSM is in IDLE.
  assign accept      = bus.pkt_valid && pkt_ready_q;
  assign hdr_bad     = bus.pkt_err || (bus.pkt_dst_dfx != bus.my_dfx);
  assign ack_load    = accept && !hdr_bad && (bus.pkt_is_ack == PKT_TYPE_ACK);
  assign data_accept = accept && !hdr_bad && (bus.pkt_is_ack != PKT_TYPE_ACK);

  ack_forward_buf #(
    .SEQ_NUM_WIDTH (SEQ_NUM_WIDTH),
    .DFX_WIDTH     (DFX_WIDTH)
  ) u_ack_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (ack_load),
    .load_src  (bus.pkt_src_dfx),
    .load_rn   (bus.pkt_sn),
    .wait_ack  (bus.wait_ack_pkt_recv),
    .valid     (fwd_valid),
    .src       (fwd_src),
    .rn        (fwd_rn),
    .overwrite (ack_overwrite)
  );

  // Data-path next state and expected-RN update.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    sn_d     = sn_q;
    exp_rn_d = exp_rn_q;
    dup      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_accept) begin
          state_d = ST_CHECK;
          src_d   = bus.pkt_src_dfx;
          sn_d    = bus.pkt_sn;
        end
      end
      ST_CHECK: begin
        if (sn_q == exp_rn_q[src_q]) begin
          state_d = ST_DELIVER;
        end else begin
          // Duplicate: re-acknowledge with the current RN, no delivery.
          dup     = 1'b1;
          state_d = ST_SEND_ACK;
        end
      end
      ST_DELIVER: begin
        if (bus.deliver_done) begin
          exp_rn_d[src_q] = exp_rn_q[src_q] + SEQ_NUM_WIDTH'(1);
          state_d         = ST_SEND_ACK;
        end
      end
      ST_SEND_ACK: begin
        if (bus.done_ack_encap) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once
  // registered; ack_rn therefore already carries the post-increment RN.
  always_comb begin
    pkt_ready_d       = (state_d == ST_IDLE);
    start_deliver_d   = (state_d == ST_DELIVER);
    deliver_src_d     = start_deliver_d ? src_d : '0;
    start_ack_encap_d = (state_d == ST_SEND_ACK);
    ack_src_d         = start_ack_encap_d ? bus.my_dfx : '0;
    ack_dst_d         = start_ack_encap_d ? src_d : '0;
    ack_rn_d          = start_ack_encap_d ? exp_rn_d[src_d] : '0;

    // Drop sources are mutually exclusive within a cycle: header filter and
    // ACK overwrite need an IDLE accept, duplicates are found in CHECK.
    drop_cnt_d = drop_cnt_q;
    if (((accept && hdr_bad) || dup || ack_overwrite) && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      src_q             <= '0;
      sn_q              <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_rn_q[i] <= '0;
      end
      pkt_ready_q       <= 1'b1;
      start_deliver_q   <= 1'b0;
      deliver_src_q     <= '0;
      start_ack_encap_q <= 1'b0;
      ack_src_q         <= '0;
      ack_dst_q         <= '0;
      ack_rn_q          <= '0;
      drop_cnt_q        <= '0;
    end else begin
      state_q           <= state_d;
      src_q             <= src_d;
      sn_q              <= sn_d;
      exp_rn_q          <= exp_rn_d;
      pkt_ready_q       <= pkt_ready_d;
      start_deliver_q   <= start_deliver_d;
      deliver_src_q     <= deliver_src_d;
      start_ack_encap_q <= start_ack_encap_d;
      ack_src_q         <= ack_src_d;
      ack_dst_q         <= ack_dst_d;
      ack_rn_q          <= ack_rn_d;
      drop_cnt_q        <= drop_cnt_d;
    end
  end

  assign bus.pkt_ready            = pkt_ready_q;
  assign bus.valid_ack_pkt_recv   = fwd_valid;
  assign bus.rn_ack_pkt_recv      = fwd_rn;
  assign bus.src_dfx_ack_pkt_recv = fwd_src;
  assign bus.start_deliver        = start_deliver_q;
  assign bus.deliver_src_dfx      = deliver_src_q;
  assign bus.start_ack_encap      = start_ack_encap_q;
  assign bus.ack_src_dfx          = ack_src_q;
  assign bus.ack_dst_dfx          = ack_dst_q;
  assign bus.ack_rn               = ack_rn_q;
  assign bus.drop_cnt             = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_recv_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_recv_controller
//  Purpose  : Self-checking bench for recv_controller: directed scenarios
//             with literal expectations, then randomized traffic compared
//             every cycle against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_recv_controller;
  import recv_pkg::*;

  localparam int SW   = SEQ_NUM_WIDTH_DEF;
  localparam int DW   = DFX_WIDTH_DEF;
  localparam int CW   = CNT_WIDTH_DEF;
  localparam int MOD  = 1 << SW;
  localparam int NSRC = 1 << DW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  recv_if #(.SEQ_NUM_WIDTH(SW), .DFX_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  recv_controller #(.SEQ_NUM_WIDTH(SW), .DFX_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // stage: 0 waiting for header, 1 judging sn, 2 delivering, 3 acknowledging
  bit m_live = 1'b0;
  int m_stage, m_src, m_sn, m_drop;
  int m_exp [NSRC];
  int aq_src [$];
  int aq_rn  [$];
  bit m_fwd;
  int m_fwd_src, m_fwd_rn;

  always @(posedge clk) begin
    int inc;
    bit acc, bad, fwd;
    if (rst) begin
      m_live = 1'b1;
      m_stage = 0; m_src = 0; m_sn = 0; m_drop = 0;
      foreach (m_exp[i]) m_exp[i] = 0;
      aq_src.delete(); aq_rn.delete();
      m_fwd = 1'b0; m_fwd_src = 0; m_fwd_rn = 0;
    end else if (m_live) begin
      inc = 0;
      acc = bus.pkt_valid && (m_stage == 0);
      bad = bus.pkt_err || (bus.pkt_dst_dfx != bus.my_dfx);
      fwd = (aq_src.size() != 0) && bus.wait_ack_pkt_recv && !m_fwd;
      m_fwd = fwd;
      if (fwd) begin
        m_fwd_src = aq_src.pop_front();
        m_fwd_rn  = aq_rn.pop_front();
      end
      if (acc && bad) inc++;
      else if (acc && (bus.pkt_is_ack == PKT_TYPE_ACK)) begin
        if (aq_src.size() != 0) begin
          inc++;
          void'(aq_src.pop_front());
          void'(aq_rn.pop_front());
        end
        aq_src.push_back(int'(bus.pkt_src_dfx));
        aq_rn.push_back(int'(bus.pkt_sn));
      end
      case (m_stage)
        0: if (acc && !bad && (bus.pkt_is_ack != PKT_TYPE_ACK)) begin
             m_stage = 1; m_src = int'(bus.pkt_src_dfx); m_sn = int'(bus.pkt_sn);
           end
        1: if (m_sn == m_exp[m_src]) m_stage = 2;
           else begin inc++; m_stage = 3; end
        2: if (bus.deliver_done) begin
             m_exp[m_src] = (m_exp[m_src] + 1) % MOD; m_stage = 3;
           end
        default: if (bus.done_ack_encap) m_stage = 0;
      endcase
      m_drop = (m_drop + inc > CMAX) ? CMAX : m_drop + inc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("pkt_ready", int'(bus.pkt_ready), int'(m_stage == 0));
      chk("start_deliver", int'(bus.start_deliver), int'(m_stage == 2));
      chk("deliver_src_dfx", int'(bus.deliver_src_dfx), (m_stage == 2) ? m_src : 0);
      chk("start_ack_encap", int'(bus.start_ack_encap), int'(m_stage == 3));
      chk("ack_src_dfx", int'(bus.ack_src_dfx), (m_stage == 3) ? int'(bus.my_dfx) : 0);
      chk("ack_dst_dfx", int'(bus.ack_dst_dfx), (m_stage == 3) ? m_src : 0);
      chk("ack_rn", int'(bus.ack_rn), (m_stage == 3) ? m_exp[m_src] : 0);
      chk("drop_cnt", int'(bus.drop_cnt), m_drop);
      chk("valid_ack", int'(bus.valid_ack_pkt_recv), int'(m_fwd));
      if (m_fwd) begin
        chk("rn_ack", int'(bus.rn_ack_pkt_recv), m_fwd_rn);
        chk("src_ack", int'(bus.src_dfx_ack_pkt_recv), m_fwd_src);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_hdr(input bit v, input bit is_ack, input int src, input int dst,
                         input int sn, input bit err);
    bus.pkt_valid   = v;
    bus.pkt_is_ack  = is_ack;
    bus.pkt_src_dfx = DW'(src);
    bus.pkt_dst_dfx = DW'(dst);
    bus.pkt_sn      = SW'(sn);
    bus.pkt_err     = err;
  endtask

  task automatic idle_hdr();
    set_hdr(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int pulses;
    bit any_req;
    bus.my_dfx = ROUTER0;
    idle_hdr();
    bus.wait_ack_pkt_recv = 1'b0;
    bus.deliver_done      = 1'b0;
    bus.done_ack_encap    = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    // reset state
    chk("rst_pkt_ready", int'(bus.pkt_ready), 1);
    chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
    chk("rst_start_deliver", int'(bus.start_deliver), 0);

    // 1: new data src=2 sn=0
    set_hdr(1'b1, 1'b0, 2, 0, 0, 1'b0);
    step(); idle_hdr();                               // N+1 (CHECK)
    chk("t1_ready_low", int'(bus.pkt_ready), 0);
    step();                                           // N+2
    chk("t1_start_deliver", int'(bus.start_deliver), 1);
    chk("t1_deliver_src", int'(bus.deliver_src_dfx), 2);
    bus.deliver_done = 1'b1;
    step(); bus.deliver_done = 1'b0;                  // N+3
    chk("t1_start_ack", int'(bus.start_ack_encap), 1);
    chk("t1_ack_dst", int'(bus.ack_dst_dfx), 2);
    chk("t1_ack_src", int'(bus.ack_src_dfx), 0);
    chk("t1_ack_rn", int'(bus.ack_rn), 1);
    chk("t1_model_exp_rn2", m_exp[2], 1);
    bus.done_ack_encap = 1'b1;
    step(); bus.done_ack_encap = 1'b0;
    chk("t1_back_idle", int'(bus.pkt_ready), 1);

    // 2: duplicate src=2 sn=0
    set_hdr(1'b1, 1'b0, 2, 0, 0, 1'b0);
    step(); idle_hdr();
    step();
    chk("t2_no_deliver", int'(bus.start_deliver), 0);
    chk("t2_start_ack", int'(bus.start_ack_encap), 1);
    chk("t2_ack_rn", int'(bus.ack_rn), 1);
    chk("t2_drop_cnt", int'(bus.drop_cnt), 1);
    bus.done_ack_encap = 1'b1;
    step(); bus.done_ack_encap = 1'b0;

    // 3: ACK src=1 rn=1, wait raised 5 cycles later
    set_hdr(1'b1, 1'b1, 1, 0, 1, 1'b0);
    step(); idle_hdr();
    pulses = 0;
    repeat (5) begin
      pulses += int'(bus.valid_ack_pkt_recv);
      step();
    end
    chk("t3_no_early_fwd", pulses, 0);
    bus.wait_ack_pkt_recv = 1'b1;
    step();
    chk("t3_valid", int'(bus.valid_ack_pkt_recv), 1);
    chk("t3_rn", int'(bus.rn_ack_pkt_recv), 1);
    chk("t3_src", int'(bus.src_dfx_ack_pkt_recv), 1);
    pulses = 0;
    repeat (3) begin
      step();
      pulses += int'(bus.valid_ack_pkt_recv);
    end
    chk("t3_single_pulse", pulses, 0);
    bus.wait_ack_pkt_recv = 1'b0;

    // 4: two ACKs before wait, newer one wins
    set_hdr(1'b1, 1'b1, 1, 0, 0, 1'b0);
    step();
    set_hdr(1'b1, 1'b1, 3, 0, 1, 1'b0);
    step(); idle_hdr();
    chk("t4_drop_cnt", int'(bus.drop_cnt), 2);
    bus.wait_ack_pkt_recv = 1'b1;
    step();
    chk("t4_valid", int'(bus.valid_ack_pkt_recv), 1);
    chk("t4_src", int'(bus.src_dfx_ack_pkt_recv), 3);
    chk("t4_rn", int'(bus.rn_ack_pkt_recv), 1);
    bus.wait_ack_pkt_recv = 1'b0;
    step();

    // 5: bad CRC, then wrong destination
    set_hdr(1'b1, 1'b0, 1, 0, 1, 1'b1);
    step();
    set_hdr(1'b1, 1'b0, 1, 3, 1, 1'b0);
    step(); idle_hdr();
    any_req = 1'b0;
    repeat (4) begin
      any_req |= bus.start_deliver | bus.start_ack_encap;
      step();
    end
    chk("t5_no_requests", int'(any_req), 0);
    chk("t5_drop_cnt", int'(bus.drop_cnt), 4);

    // 6: reset during DELIVER
    set_hdr(1'b1, 1'b0, 1, 0, 0, 1'b0);
    step(); idle_hdr();
    step();
    chk("t6_in_deliver", int'(bus.start_deliver), 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("t6_ready", int'(bus.pkt_ready), 1);
    chk("t6_start_deliver", int'(bus.start_deliver), 0);
    chk("t6_deliver_src", int'(bus.deliver_src_dfx), 0);
    chk("t6_start_ack", int'(bus.start_ack_encap), 0);
    chk("t6_drop_cnt", int'(bus.drop_cnt), 0);
    chk("t6_valid_ack", int'(bus.valid_ack_pkt_recv), 0);
    set_hdr(1'b1, 1'b0, 2, 0, 0, 1'b0);              // exp_rn[2] back to 0
    step(); idle_hdr();
    step();
    chk("t6_new_deliver", int'(bus.start_deliver), 1);
    chk("t6_new_src", int'(bus.deliver_src_dfx), 2);
    bus.deliver_done = 1'b1;
    step(); bus.deliver_done = 1'b0;
    chk("t6_ack_rn", int'(bus.ack_rn), 1);
    bus.done_ack_encap = 1'b1;
    step(); bus.done_ack_encap = 1'b0;

    // drop_cnt saturation
    set_hdr(1'b1, 1'b0, 0, 0, 0, 1'b1);
    repeat (CMAX + 5) step();
    idle_hdr();
    step();
    chk("sat_drop_cnt", int'(bus.drop_cnt), CMAX);

    // randomized traffic, different router ID
    rst = 1'b1;
    bus.my_dfx = ROUTER2;
    step(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      bus.pkt_valid   = ($urandom_range(0, 99) < 50);
      bus.pkt_is_ack  = ($urandom_range(0, 99) < 40);
      bus.pkt_src_dfx = DW'($urandom_range(0, NSRC - 1));
      bus.pkt_dst_dfx = ($urandom_range(0, 99) < 80) ? bus.my_dfx : DW'($urandom_range(0, NSRC - 1));
      bus.pkt_sn      = SW'($urandom_range(0, MOD - 1));
      bus.pkt_err     = ($urandom_range(0, 99) < 8);
      bus.wait_ack_pkt_recv = ($urandom_range(0, 99) < 30);
      bus.deliver_done      = ($urandom_range(0, 99) < 40);
      bus.done_ack_encap    = ($urandom_range(0, 99) < 40);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    idle_hdr();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
